// File: rtl/serdes_rx_deframer.sv
// Hunts the three-word sync sequence, decodes the header and delivers the payload as a framed stream.
// Latency: one registered cycle from an accepted word to its outputs. No backpressure: data is taken whenever I_data_ena is high.
module serdes_rx_deframer #(
    parameter logic [15:0] P_SYNC_W0 = 16'hbaf1,
    parameter logic [15:0] P_SYNC_W1 = 16'hff84,
    parameter logic [15:0] P_SYNC_W2 = 16'h69aa,
    parameter int          P_GAP_MAX = 16
) (
    input  logic        I_serdes_rx_clk,
    input  logic        I_rst,
    input  logic [15:0] I_user_data,
    input  logic        I_data_ena,
    output logic [15:0] O_frame_data,
    output logic        O_frame_ena,
    output logic        O_frame_sop,
    output logic        O_frame_eop,
    output logic [5:0]  O_frame_type,
    output logic [9:0]  O_frame_len,
    output logic        O_frame_err,
    output logic [1:0]  O_err_code,
    output logic [15:0] O_frame_cnt,
    output logic [7:0]  O_err_cnt,
    output logic        O_locked
);

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        SYNC1   = 3'd1,
        SYNC2   = 3'd2,
        HDR     = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(P_GAP_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] gap_cnt;
    logic [9:0] remain;
    logic       first_word;

    logic       hdr_ok;
    logic       hdr_zero;
    logic       word_fwd;
    logic       word_last;
    logic       gap_abort;

    always_ff @(posedge I_serdes_rx_clk or posedge I_rst) begin
        if (I_rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hdr_ok    = 1'b0;
        hdr_zero  = 1'b0;
        word_fwd  = 1'b0;
        word_last = 1'b0;
        gap_abort = 1'b0;
        if (I_data_ena) begin
            case (state)
                HUNT: begin
                    if (I_user_data == P_SYNC_W0) state_nxt = SYNC1;
                end
                SYNC1: begin
                    if (I_user_data == P_SYNC_W1)      state_nxt = SYNC2;
                    else if (I_user_data == P_SYNC_W0) state_nxt = SYNC1;
                    else                               state_nxt = HUNT;
                end
                SYNC2: begin
                    if (I_user_data == P_SYNC_W2)      state_nxt = HDR;
                    else if (I_user_data == P_SYNC_W0) state_nxt = SYNC1;
                    else                               state_nxt = HUNT;
                end
                HDR: begin
                    if (I_user_data[9:0] == 10'd0) begin
                        hdr_zero  = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        hdr_ok    = 1'b1;
                        state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // Payload is never matched against sync words; only the length ends it.
                    word_fwd = 1'b1;
                    if (remain == 10'd1) begin
                        word_last = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end else if (state != HUNT && gap_cnt == GAP_LAST) begin
            gap_abort = 1'b1;
            state_nxt = HUNT;
        end
    end

    always_ff @(posedge I_serdes_rx_clk or posedge I_rst) begin
        if (I_rst) begin
            gap_cnt    <= 8'd0;
            remain     <= 10'd0;
            first_word <= 1'b0;
        end else begin
            if (I_data_ena || state_nxt == HUNT) begin
                gap_cnt <= 8'd0;
            end else if (state != HUNT) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
            if (hdr_ok) begin
                remain     <= I_user_data[9:0];
                first_word <= 1'b1;
            end else if (word_fwd) begin
                remain     <= remain - 10'd1;
                first_word <= 1'b0;
            end
        end
    end

    // Output stage: everything visible one cycle after the word that caused it.
    always_ff @(posedge I_serdes_rx_clk or posedge I_rst) begin
        if (I_rst) begin
            O_frame_data <= 16'd0;
            O_frame_ena  <= 1'b0;
            O_frame_sop  <= 1'b0;
            O_frame_eop  <= 1'b0;
            O_frame_type <= 6'd0;
            O_frame_len  <= 10'd0;
            O_frame_err  <= 1'b0;
            O_err_code   <= 2'b00;
            O_frame_cnt  <= 16'd0;
            O_err_cnt    <= 8'd0;
            O_locked     <= 1'b0;
        end else begin
            O_frame_ena <= word_fwd;
            O_frame_sop <= word_fwd & first_word;
            O_frame_eop <= word_last;
            O_frame_err <= hdr_zero | gap_abort;
            if (word_fwd) O_frame_data <= I_user_data;
            if (hdr_ok) begin
                O_frame_type <= I_user_data[15:10];
                O_frame_len  <= I_user_data[9:0];
            end
            if (hdr_zero)  O_err_code <= 2'b10;
            if (gap_abort) O_err_code <= 2'b01;
            if ((hdr_zero || gap_abort) && O_err_cnt != 8'hff) O_err_cnt <= O_err_cnt + 8'd1;
            if (word_last) O_frame_cnt <= O_frame_cnt + 16'd1;
            if (hdr_ok)                      O_locked <= 1'b1;
            else if (word_last || gap_abort) O_locked <= 1'b0;
        end
    end

endmodule

// File: doc/serdes_rx_deframer.md
Name: serdes_rx_deframer

Overview:
- Sits directly downstream of the serdes RX interface in the same clock domain.
- Consumes its aligned 16-bit user-data stream, which carries an enable and has idle gaps where comma words were dropped.
- Hunts for the three-word sync sequence, decodes a one-word header, and delivers the payload as a framed stream with start/end markers.
- Flags gap timeouts and illegal headers, and keeps frame and error counters for status readback.

Parameters:
P_SYNC_W0, 16'hbaf1, first sync word as presented at I_user_data
P_SYNC_W1, 16'hff84, second sync word
P_SYNC_W2, 16'h69aa, third sync word
P_GAP_MAX, 16, consecutive idle cycles mid-frame that abort the frame (range 2..255)

Ports:
I_serdes_rx_clk  input  1   rx user clock; all logic on its rising edge
I_rst  input  1   asynchronous active-high reset
I_user_data  input  16  aligned rx word
I_data_ena  input  1   I_user_data valid this cycle
O_frame_data  output  16  payload word
O_frame_ena  output  1   O_frame_data valid
O_frame_sop  output  1   first payload word of frame (qualified by O_frame_ena)
O_frame_eop  output  1   last payload word of frame (qualified by O_frame_ena)
O_frame_type  output  6   header type field of current/last frame
O_frame_len  output  10  header length field of current/last frame
O_frame_err  output  1   one-cycle abort pulse
O_err_code  output  2   01 gap timeout, 10 zero length; valid with O_frame_err, held until next error
O_frame_cnt  output  16  completed frames, wraps
O_err_cnt  output  8   aborted frames, saturates at 8'hff
O_locked  output  1   high from header accept until frame end/abort

Behaviour:
- Interface: one clock, I_serdes_rx_clk. Reset I_rst is asynchronous and active-high. All outputs reset to 0. State resets to HUNT and the gap counter to 0.
- Words are processed only in cycles where I_data_ena=1. Cycles with I_data_ena=0 change no state except the gap counter.
- FSM states: HUNT, SYNC1, SYNC2, HDR, PAYLOAD.
  - HUNT: a word equal to W0 moves to SYNC1; any other word stays in HUNT.
  - SYNC1: W1 moves to SYNC2. W0 stays in SYNC1 (restart). Any other word goes to HUNT.
  - SYNC2: W2 moves to HDR. W0 goes to SYNC1. Any other word goes to HUNT.
  - HDR: the next valid word is the header: [15:10] is the type, [9:0] is the length in words.
    - Length 0: O_frame_err=1 and O_err_code=10 for one cycle, O_err_cnt increments, go to HUNT.
    - Otherwise: latch O_frame_type and O_frame_len, load the remaining counter with the length, set O_locked=1, go to PAYLOAD.
  - PAYLOAD: each valid word is forwarded and the remaining counter decrements.
    - The first payload word asserts sop. The word at remaining=1 asserts eop.
    - On eop: O_frame_cnt increments, O_locked clears, go to HUNT. Length 1 asserts sop and eop on the same word.
    - Payload contents are never compared against the sync words.
- Latency: a payload word accepted in cycle N appears on O_frame_data/O_frame_ena/sop/eop in cycle N+1, registered. O_frame_ena is 0 in all other cycles. O_frame_data holds its last value when not valid.
- The header is not forwarded.
- Gap counter (8-bit) runs only in SYNC1, SYNC2, HDR and PAYLOAD.
  - It clears on every valid word and on entry to HUNT.
  - Each idle cycle increments it.
  - When it reaches P_GAP_MAX: O_frame_err=1 and O_err_code=01 for one cycle, O_err_cnt increments (saturating), O_locked clears, go to HUNT.
  - A partly delivered frame gets no eop; the abort pulse is the terminator.
  - In HUNT, gaps are unlimited and ignored.
- Error pulses land in the cycle after the triggering condition, aligned with the output register stage. Frame and error events can never occur in the same cycle.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). No eop or err is emitted for the truncated frame. Counters clear.

Test Plan:
- Stream idle, then f1ba? no — words baf1,ff84,69aa,0403 (type 1, len 3),1111,2222,3333 with I_data_ena=1 → O_frame_data 1111/2222/3333, sop on 1111, eop on 3333, each one cycle after input; O_frame_type=1, O_frame_len=3, O_frame_cnt=1.
- baf1,baf1,ff84,69aa,0001,abcd → restart at second baf1 accepted; single word abcd with sop=eop=1; O_frame_cnt=1.
- baf1,ff84,1234,69aa,0002,... → return to HUNT on 1234; no frame output; counters unchanged.
- Valid sync, header 0005, two payload words, then I_data_ena=0 for 16 cycles → O_frame_err pulse, O_err_code=01, O_err_cnt=1, O_locked=0, no eop; a following good frame decodes normally.
- Sync then header 0xFC00 (type 3F, len 0) → O_frame_err, O_err_code=10, O_err_cnt=1; no O_frame_ena.
- Payload with 3 idle cycles inserted between every word, len 4 → all 4 words delivered, no error; then assert I_rst mid-second-frame → all outputs 0 at once, FSM back in HUNT.
